// File: rtl/updown_mod_counter_pkg.sv
// Shared constants, next-state select type and parameter check for updown_mod_counter.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        NS_HOLD,
        NS_LOAD,
        NS_INC,
        NS_DEC,
        NS_WRAP
    } ns_sel_e;

    // A modulo fits the counter when it needs no more than data_size bits to index 0..modulo-1.
    function automatic bit counter_params_ok(input int data_size, input longint unsigned modulo);
        if (data_size < 2 || data_size > 32) return 1'b0;
        if (modulo < 2) return 1'b0;
        return ($clog2(modulo) <= data_size);
    endfunction

endpackage

// File: rtl/updown_mod_counter_next.sv
// Combinational step logic: next count, wrap/saturation event and clamped load value.
// Build option UPDOWN_MOD_COUNTER_SATURATE_EN selects saturating instead of wrapping steps.
module updown_mod_counter_next
    import counter_pkg::*;
#(
    parameter int              DATA_SIZE = 4,
    parameter longint unsigned MODULO    = 16
) (
    input  logic [DATA_SIZE-1:0] q,
    input  logic                 up_dn,
    input  logic [DATA_SIZE-1:0] load_val,
    output logic [DATA_SIZE-1:0] q_step,
    output ns_sel_e              step_sel,
    output logic                 step_evt,
    output logic [DATA_SIZE-1:0] load_clamped
);

    localparam longint unsigned    MOD_MAX_L = MODULO - 1;
    localparam logic [DATA_SIZE:0] MOD_MAX   = MOD_MAX_L[DATA_SIZE:0];
    localparam logic [DATA_SIZE:0] ONE       = {{DATA_SIZE{1'b0}}, 1'b1};
    localparam logic [DATA_SIZE:0] ZERO      = '0;

    logic [DATA_SIZE:0] q_ext;
    logic [DATA_SIZE:0] inc;
    logic [DATA_SIZE:0] dec;
    logic [DATA_SIZE:0] ld_ext;

    assign q_ext  = {1'b0, q};
    assign inc    = q_ext + ONE;
    assign dec    = q_ext - ONE;
    assign ld_ext = {1'b0, load_val};

    assign load_clamped = (ld_ext > MOD_MAX) ? MOD_MAX[DATA_SIZE-1:0] : load_val;

    // The extra bit makes "past the top" and "borrow below zero" visible for any modulo.
    always_comb begin
        q_step   = q;
        step_sel = NS_HOLD;
        step_evt = 1'b0;
        if (up_dn == DIR_UP) begin
            if (inc > MOD_MAX) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
                q_step   = MOD_MAX[DATA_SIZE-1:0];
                step_sel = NS_HOLD;
`else
                q_step   = '0;
                step_sel = NS_WRAP;
                step_evt = 1'b1;
`endif
            end else begin
                q_step   = inc[DATA_SIZE-1:0];
                step_sel = NS_INC;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
                step_evt = (inc == MOD_MAX);
`endif
            end
        end else begin
            if (dec[DATA_SIZE]) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
                q_step   = '0;
                step_sel = NS_HOLD;
`else
                q_step   = MOD_MAX[DATA_SIZE-1:0];
                step_sel = NS_WRAP;
                step_evt = 1'b1;
`endif
            end else begin
                q_step   = dec[DATA_SIZE-1:0];
                step_sel = NS_DEC;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
                step_evt = (dec == ZERO);
`endif
            end
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, registered wrap pulse and compare match.
// Build option UPDOWN_MOD_COUNTER_SATURATE_EN makes it saturate; wrap then flags entry into saturation.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int              DATA_SIZE = 4,
    parameter longint unsigned MODULO    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [DATA_SIZE-1:0] load_val,
    input  logic [DATA_SIZE-1:0] cmp_val,
    output logic [DATA_SIZE-1:0] q_out,
    output logic                 wrap,
    output logic                 match
);

    generate
        if (!counter_params_ok(DATA_SIZE, MODULO)) begin : g_param_check
            $error("updown_mod_counter: DATA_SIZE must be 2..32 and MODULO 2..2**DATA_SIZE");
        end
    endgenerate

    logic [DATA_SIZE-1:0] q_step;
    logic [DATA_SIZE-1:0] load_clamped;
    logic [DATA_SIZE-1:0] q_next;
    logic                 step_evt;
    logic                 wrap_next;
    ns_sel_e              step_sel;
    ns_sel_e              sel;

    updown_mod_counter_next #(
        .DATA_SIZE (DATA_SIZE),
        .MODULO    (MODULO)
    ) u_next (
        .q            (q_out),
        .up_dn        (up_dn),
        .load_val     (load_val),
        .q_step       (q_step),
        .step_sel     (step_sel),
        .step_evt     (step_evt),
        .load_clamped (load_clamped)
    );

    always_comb begin
        sel       = NS_HOLD;
        wrap_next = 1'b0;
        if (load) begin
            sel = NS_LOAD;
        end else if (en) begin
            sel       = step_sel;
            wrap_next = step_evt;
        end
        case (sel)
            NS_LOAD:                 q_next = load_clamped;
            NS_INC, NS_DEC, NS_WRAP: q_next = q_step;
            default:                 q_next = q_out;
        endcase
    end

    // q_next never leaves 0..MODULO-1, so an out-of-range cmp_val can never match.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_out <= '0;
            wrap  <= 1'b0;
            match <= 1'b0;
        end else begin
            q_out <= q_next;
            wrap  <= wrap_next;
            match <= (q_next == cmp_val);
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: integer model of the counting rules plus directed literal expectations.
module tb_updown_mod_counter;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         en       = 1'b0;
    logic         up_dn    = 1'b1;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] cmp_val  = '0;

    logic [W-1:0] q_a, q_f;
    logic         wrap_a, wrap_f, match_a, match_f;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    updown_mod_counter #(.DATA_SIZE(W), .MODULO(10)) u_dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cmp_val(cmp_val),
        .q_out(q_a), .wrap(wrap_a), .match(match_a)
    );

    updown_mod_counter #(.DATA_SIZE(W), .MODULO(16)) u_full (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .cmp_val(cmp_val),
        .q_out(q_f), .wrap(wrap_f), .match(match_f)
    );

    typedef struct {
        int q;
        bit w;
        bit m;
    } mstate_t;

    mstate_t exp_a, exp_f;

    function automatic mstate_t mstep(input mstate_t s, input int m, input bit rst, input bit ld,
                                      input bit e, input bit u, input int lv, input int cv);
        mstate_t n;
        n.q = s.q;
        n.w = 1'b0;
        n.m = 1'b0;
        if (rst) return n.q == n.q ? '{0, 1'b0, 1'b0} : n;
        if (ld) begin
            n.q = (lv >= m) ? m - 1 : lv;
        end else if (e) begin
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
            if (u) begin
                if (s.q < m - 1) begin
                    n.q = s.q + 1;
                    n.w = (n.q == m - 1);
                end
            end else if (s.q > 0) begin
                n.q = s.q - 1;
                n.w = (n.q == 0);
            end
`else
            n.q = u ? (s.q + 1) % m : (s.q + m - 1) % m;
            n.w = u ? (s.q == m - 1) : (s.q == 0);
`endif
        end
        n.m = (n.q == cv);
        return n;
    endfunction

    always @(posedge clk) begin
        exp_a <= mstep(exp_a, 10, reset, load, en, up_dn, int'(load_val), int'(cmp_val));
        exp_f <= mstep(exp_f, 16, reset, load, en, up_dn, int'(load_val), int'(cmp_val));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q10",     32'(q_a),     exp_a.q);
            check("model_wrap10",  32'(wrap_a),  32'(exp_a.w));
            check("model_match10", 32'(match_a), 32'(exp_a.m));
            check("model_q16",     32'(q_f),     exp_f.q);
            check("model_wrap16",  32'(wrap_f),  32'(exp_f.w));
            check("model_match16", 32'(match_f), 32'(exp_f.m));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int qe, input bit we, input bit me);
        check({name, "_q"},     32'(q_a),     qe);
        check({name, "_wrap"},  32'(wrap_a),  32'(we));
        check({name, "_match"}, 32'(match_a), 32'(me));
    endtask

    initial begin
        int e;
        bit seen;

        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        lit("reset", 0, 1'b0, 1'b0);

        // count up from 0 with compare at 6
        cmp_val = 4'd6;
        en      = 1'b1;
        up_dn   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
            e = (i + 1 > 9) ? 9 : i + 1;
            lit($sformatf("up%0d", i), e, (i + 1 == 9), (e == 6));
`else
            e = (i + 1) % 10;
            lit($sformatf("up%0d", i), e, (e == 0), (e == 6));
`endif
        end

        // down through zero
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd1;
        tick();
        load = 1'b0;
        lit("dn_load", 1, 1'b0, 1'b0);
        en    = 1'b1;
        up_dn = 1'b0;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
        tick(); lit("dn0", 0, 1'b1, 1'b0);
        tick(); lit("dn1", 0, 1'b0, 1'b0);
        tick(); lit("dn2", 0, 1'b0, 1'b0);
`else
        tick(); lit("dn0", 0, 1'b0, 1'b0);
        tick(); lit("dn1", 9, 1'b1, 1'b0);
        tick(); lit("dn2", 8, 1'b0, 1'b0);
`endif

        // load priority and clamp
        load     = 1'b1;
        load_val = 4'd13;
        en       = 1'b1;
        up_dn    = 1'b1;
        tick(); lit("clamp", 9, 1'b0, 1'b0);
        load_val = 4'd4;
        up_dn    = 1'b0;
        tick(); lit("load_en", 4, 1'b0, 1'b0);
        up_dn = 1'b1;
        en    = 1'b0;
        tick(); lit("load_noen", 4, 1'b0, 1'b0);

        // out-of-range compare never matches on the modulo-10 counter
        cmp_val  = 4'd12;
        load_val = 4'd0;
        tick();
        load = 1'b0;
        en   = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen |= match_a;
        end
        check("cmp_out_of_range", 32'(seen), 32'd0);

        // mid-count reset then hold
        cmp_val  = 4'd0;
        load     = 1'b1;
        load_val = 4'd5;
        tick();
        load = 1'b0;
        tick();
        tick();
        lit("pre_reset", 7, 1'b0, 1'b0);
        reset = 1'b1;
        tick(); lit("mid_reset", 0, 1'b0, 1'b0);
        reset = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            lit($sformatf("hold%0d", i), 0, 1'b0, 1'b1);
        end

`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
        load     = 1'b1;
        load_val = 4'd8;
        tick();
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        tick(); lit("sat_up0", 9, 1'b1, 1'b0);
        tick(); lit("sat_up1", 9, 1'b0, 1'b0);
        tick(); lit("sat_up2", 9, 1'b0, 1'b0);
        load     = 1'b1;
        load_val = 4'd1;
        tick();
        load  = 1'b0;
        up_dn = 1'b0;
        tick(); lit("sat_dn0", 0, 1'b1, 1'b1);
        tick(); lit("sat_dn1", 0, 1'b0, 1'b1);
`else
        // direction changes take effect on the same edge
        cmp_val  = 4'd5;
        load     = 1'b1;
        load_val = 4'd5;
        tick();
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1; tick(); lit("dir0", 6, 1'b0, 1'b0);
        up_dn = 1'b0; tick(); lit("dir1", 5, 1'b0, 1'b1);
        up_dn = 1'b0; tick(); lit("dir2", 4, 1'b0, 1'b0);
        up_dn = 1'b1; tick(); lit("dir3", 5, 1'b0, 1'b1);
`endif

        // mixed traffic checked against the model only
        for (int i = 0; i < 80; i++) begin
            en       = 1'($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom_range(0, 1));
            load     = 1'($urandom_range(0, 9) == 0);
            reset    = 1'($urandom_range(0, 29) == 0);
            load_val = 4'($urandom_range(0, 15));
            cmp_val  = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
